// File: rtl/fo_scan.sv
// Two-stage find-first / find-last scanner with valid/ready handshaking on both sides.
// Optional population count output is enabled by defining FO_SCAN_POPCNT_EN.
module fo_scan #(
  parameter int WID = 96,
  parameter int SEG = 24,
  localparam int PW = $clog2(WID + 1)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           i_valid,
  output logic           i_ready,
  input  logic [WID-1:0] i_data,
  input  logic           i_dir,
  output logic           o_valid,
  input  logic           o_ready,
  output logic [PW-1:0]  o_pos,
`ifdef FO_SCAN_POPCNT_EN
  output logic [PW-1:0]  o_cnt,
`endif
  output logic           o_none
);

  localparam int NSEG = WID / SEG;
  localparam int LW   = (SEG > 1) ? $clog2(SEG) : 1;
  localparam logic [PW-1:0] NONE = '1;

  // Lowest (dir=0) or highest (dir=1) set bit inside one segment; 0 when empty.
  function automatic logic [LW-1:0] scan_seg(input logic [SEG-1:0] s, input logic dir);
    logic [LW-1:0] idx;
    idx = '0;
    for (int b = 0; b < SEG; b++) begin
      if (dir) begin
        if (s[b]) idx = LW'(b);
      end else begin
        if (s[SEG-1-b]) idx = LW'(SEG-1-b);
      end
    end
    return idx;
  endfunction

  logic            r_vld_p1;
  logic [NSEG-1:0] r_hit_p1;
  logic [LW-1:0]   r_lidx_p1 [NSEG];
  logic            r_dir_p1;
  logic            r_vld_p2;
  logic [PW-1:0]   r_pos_p2;
  logic            r_none_p2;

  logic            w_adv_p2;
  logic [NSEG-1:0] w_hit_p0;
  logic [LW-1:0]   w_lidx_p0 [NSEG];
  logic [PW-1:0]   w_pos_p1;
  logic            w_none_p1;

  // Stage 2 can load whenever it is empty or its word leaves this cycle.
  assign w_adv_p2 = !r_vld_p2 || o_ready;
  assign i_ready  = !r_vld_p1 || w_adv_p2;

  assign o_valid  = r_vld_p2;
  assign o_pos    = r_pos_p2;
  assign o_none   = r_none_p2;

  // ---- stage 0 -> 1: per-segment hit flag and local index ----
  always_comb begin
    w_hit_p0 = '0;
    for (int s = 0; s < NSEG; s++) begin
      w_hit_p0[s]  = |i_data[s*SEG +: SEG];
      w_lidx_p0[s] = scan_seg(i_data[s*SEG +: SEG], i_dir);
    end
  end

  always_ff @(posedge clk_i) begin
    if (i_valid && i_ready) begin
      r_hit_p1  <= w_hit_p0;
      r_lidx_p1 <= w_lidx_p0;
      r_dir_p1  <= i_dir;
    end
  end

  // ---- stage 1 -> 2: pick the winning segment ----
  // dir=0 keeps the first hit found; dir=1 lets every later hit overwrite it.
  always_comb begin
    w_none_p1 = 1'b1;
    w_pos_p1  = NONE;
    for (int s = 0; s < NSEG; s++) begin
      if (r_hit_p1[s] && (w_none_p1 || r_dir_p1)) begin
        w_none_p1 = 1'b0;
        w_pos_p1  = PW'(s * SEG) + PW'(r_lidx_p1[s]);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld_p1  <= 1'b0;
      r_vld_p2  <= 1'b0;
      r_pos_p2  <= NONE;
      r_none_p2 <= 1'b1;
    end else begin
      if (i_ready) r_vld_p1 <= i_valid;
      if (w_adv_p2) begin
        r_vld_p2 <= r_vld_p1;
        if (r_vld_p1) begin
          r_pos_p2  <= w_pos_p1;
          r_none_p2 <= w_none_p1;
        end
      end
    end
  end

`ifdef FO_SCAN_POPCNT_EN
  localparam int CW = $clog2(SEG + 1);

  function automatic logic [CW-1:0] cnt_seg(input logic [SEG-1:0] s);
    logic [CW-1:0] c;
    c = '0;
    for (int b = 0; b < SEG; b++) c = c + CW'(s[b]);
    return c;
  endfunction

  logic [CW-1:0] r_cnt_p1 [NSEG];
  logic [CW-1:0] w_cnt_p0 [NSEG];
  logic [PW-1:0] r_cnt_p2;
  logic [PW-1:0] w_cnt_p1;

  always_comb begin
    for (int s = 0; s < NSEG; s++) w_cnt_p0[s] = cnt_seg(i_data[s*SEG +: SEG]);
  end

  always_ff @(posedge clk_i) begin
    if (i_valid && i_ready) r_cnt_p1 <= w_cnt_p0;
  end

  always_comb begin
    w_cnt_p1 = '0;
    for (int s = 0; s < NSEG; s++) w_cnt_p1 = w_cnt_p1 + PW'(r_cnt_p1[s]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_cnt_p2 <= '0;
    else if (w_adv_p2 && r_vld_p1) r_cnt_p2 <= w_cnt_p1;
  end

  assign o_cnt = r_cnt_p2;
`endif

endmodule

// File: tb/tb_fo_scan.sv
// Scoreboard bench for fo_scan at WID=96, SEG=24 (covers o_cnt when FO_SCAN_POPCNT_EN is defined).
module tb_fo_scan;

  localparam int WID = 96;
  localparam int PW  = 7;

  typedef struct {
    logic [PW-1:0] pos;
    logic          none;
    logic [PW-1:0] cnt;
    int            acc;
    bit            lat;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_i, i_valid, i_ready, i_dir, o_valid, o_ready, o_none;
  logic [WID-1:0] i_data;
  logic [PW-1:0]  o_pos;
`ifdef FO_SCAN_POPCNT_EN
  logic [PW-1:0]  o_cnt;
`endif

  exp_t q[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  fo_scan #(.WID(WID), .SEG(24)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_data  (i_data),
    .i_dir   (i_dir),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_pos   (o_pos),
`ifdef FO_SCAN_POPCNT_EN
    .o_cnt   (o_cnt),
`endif
    .o_none  (o_none)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Present one word from posedge+1 until accepted; push its expectation at the accepting negedge.
  task automatic send(input logic [WID-1:0] d, input logic dir, input int pos,
                      input logic none, input int cnt, input bit lat);
    exp_t e;
    int   tmo;
    i_valid = 1'b1;
    i_data  = d;
    i_dir   = dir;
    tmo     = 0;
    forever begin
      @(negedge clk);
      if (i_ready) break;
      tmo++;
      if (tmo > 50) begin
        n_cmp++;
        n_bad++;
        $display("FAIL accept_timeout: got no i_ready, expected accept within 50 cycles");
        break;
      end
    end
    if (tmo <= 50) begin
      e.pos  = PW'(pos);
      e.none = none;
      e.cnt  = PW'(cnt);
      e.acc  = cyc;
      e.lat  = lat;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain_queue_empty", q.size(), 0);
  endtask

  // Monitor: every output transfer pops one expectation.
  always @(negedge clk) begin
    if (o_valid && o_ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got pos %0d with empty scoreboard, expected no output", o_pos);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("o_pos", o_pos, e.pos);
        chk("o_none", o_none, e.none);
`ifdef FO_SCAN_POPCNT_EN
        chk("o_cnt", o_cnt, e.cnt);
`endif
        if (e.lat) chk("latency", cyc - e.acc, 2);
      end
    end
  end

  logic [WID-1:0] tv_d   [12];
  logic           tv_dir [12];
  int             tv_pos [12];
  logic           tv_non [12];
  int             tv_cnt [12];
  logic [WID-1:0] one;

  initial begin
    one = 1;
    tv_d[0]  = '0;                        tv_dir[0]  = 0; tv_pos[0]  = 127; tv_non[0]  = 1; tv_cnt[0]  = 0;
    tv_d[1]  = (one << 5) | (one << 80);  tv_dir[1]  = 0; tv_pos[1]  = 5;   tv_non[1]  = 0; tv_cnt[1]  = 2;
    tv_d[2]  = (one << 5) | (one << 80);  tv_dir[2]  = 1; tv_pos[2]  = 80;  tv_non[2]  = 0; tv_cnt[2]  = 2;
    tv_d[3]  = one;                       tv_dir[3]  = 1; tv_pos[3]  = 0;   tv_non[3]  = 0; tv_cnt[3]  = 1;
    tv_d[4]  = one << 95;                 tv_dir[4]  = 0; tv_pos[4]  = 95;  tv_non[4]  = 0; tv_cnt[4]  = 1;
    tv_d[5]  = '1;                        tv_dir[5]  = 0; tv_pos[5]  = 0;   tv_non[5]  = 0; tv_cnt[5]  = 96;
    tv_d[6]  = '1;                        tv_dir[6]  = 1; tv_pos[6]  = 95;  tv_non[6]  = 0; tv_cnt[6]  = 96;
    tv_d[7]  = 96'hF0;                    tv_dir[7]  = 0; tv_pos[7]  = 4;   tv_non[7]  = 0; tv_cnt[7]  = 4;
    tv_d[8]  = 96'hF0;                    tv_dir[8]  = 1; tv_pos[8]  = 7;   tv_non[8]  = 0; tv_cnt[8]  = 4;
    tv_d[9]  = (one << 23) | (one << 24); tv_dir[9]  = 0; tv_pos[9]  = 23;  tv_non[9]  = 0; tv_cnt[9]  = 2;
    tv_d[10] = (one << 23) | (one << 24); tv_dir[10] = 1; tv_pos[10] = 24;  tv_non[10] = 0; tv_cnt[10] = 2;
    tv_d[11] = '0;                        tv_dir[11] = 1; tv_pos[11] = 127; tv_non[11] = 1; tv_cnt[11] = 0;

    rst_i = 1'b1; i_valid = 1'b0; i_data = '0; i_dir = 1'b0; o_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_pos", o_pos, 127);
    chk("rst_o_none", o_none, 1);
    chk("rst_i_ready", i_ready, 1);
    @(posedge clk);
    #1;

    // Back-to-back table with o_ready high: each result exactly two cycles after its accept.
    for (int i = 0; i < 12; i++) send(tv_d[i], tv_dir[i], tv_pos[i], tv_non[i], tv_cnt[i], 1'b1);
    drain();
    @(posedge clk);
    #1;

    // Backpressure: three words offered while the consumer stalls.
    o_ready = 1'b0;
    fork
      begin
        send(one << 10, 1'b0, 10, 1'b0, 1, 1'b0);
        send((one << 70) | (one << 71), 1'b1, 71, 1'b0, 2, 1'b0);
        send(one << 48, 1'b0, 48, 1'b0, 1, 1'b0);
      end
      begin
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
          if (k != 0) @(negedge clk);
          chk("stall_i_ready", i_ready, 0);
          chk("stall_o_valid", o_valid, 1);
          chk("stall_o_pos", o_pos, 10);
          chk("stall_o_none", o_none, 0);
        end
        @(posedge clk);
        #1 o_ready = 1'b1;
      end
    join
    drain();
    @(posedge clk);
    #1;

    // Mid-stream reset with two words in flight and a word offered on the reset edge.
    o_ready = 1'b0;
    send(one << 33, 1'b0, 33, 1'b0, 1, 1'b0);
    send(one << 66, 1'b1, 66, 1'b0, 1, 1'b0);
    rst_i   = 1'b1;
    i_valid = 1'b1;
    i_data  = one << 12;
    q.delete();
    @(posedge clk);
    #1;
    rst_i   = 1'b0;
    i_valid = 1'b0;
    @(negedge clk);
    chk("midrst_o_valid", o_valid, 0);
    chk("midrst_o_pos", o_pos, 127);
    chk("midrst_o_none", o_none, 1);
    chk("midrst_i_ready", i_ready, 1);
    o_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst_no_emit", o_valid, 0);
    @(posedge clk);
    #1;

    send(one << 60, 1'b0, 60, 1'b0, 1, 1'b1);
    drain();
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
